dp_ram_fifo_ctrl: RTL

Synchronous FIFO controller that turns the 64x8 `dual_port_ram` into a first-word-fall-through stream buffer. Port A of the RAM is the write port and port B is the read port. The block sits directly upstream of the RAM: it generates every RAM address, data and write-enable, and it consumes `data_out_b`. It adds valid/ready handshakes on both sides and a 2-entry output skid buffer that hides the RAM's one-cycle read latency, so the block sustains one word per cycle.

---
 rtl/dp_ram_fifo_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dp_ram_fifo_ctrl.sv
// dp_ram_fifo_ctrl: first-word-fall-through FIFO controller wrapped around a
// 64x8 dual-port RAM (port A writes, port B reads). A 2-entry skid buffer
// absorbs the RAM's one-cycle read latency so one word per cycle streams.
// Optional feature macro: DPF_OVF_FLAG_EN adds a sticky overflow flag
// (ovf_err) with a clear input (err_clr).
module dp_ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  input  logic              pop_ready,
  output logic [ADDR_W+1:0] level,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_in_a,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_data_out_b
`ifdef DPF_OVF_FLAG_EN
  ,
  input  logic              err_clr,
  output logic              ovf_err
`endif
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   ram_cnt_r;
  logic              rd_inflight_r;
  logic [DATA_W-1:0] skid_r [0:1];
  logic [1:0]        skid_cnt_r;
  logic [ADDR_W+1:0] level_r;

  logic              push_fire_s;
  logic              pop_fire_s;
  logic              rd_issue_s;
  logic [ADDR_W:0]   ram_cnt_nxt_s;
  logic [1:0]        skid_after_pop_s;
  logic [1:0]        skid_cnt_nxt_s;
  logic [DATA_W-1:0] skid0_nxt_s;
  logic [DATA_W-1:0] skid1_nxt_s;
  logic [ADDR_W+1:0] level_nxt_s;

  // Status flags come straight from registered state only.
  assign push_ready = (ram_cnt_r != FULL_CNT);
  assign pop_valid  = (skid_cnt_r != 2'd0);
  assign pop_data   = skid_r[0];
  assign level      = level_r;

  // Gating with rst_n keeps the RAM write port quiet while reset is held,
  // even though push_ready already reads 1 in that state.
  assign push_fire_s = push_valid & push_ready & rst_n;
  assign pop_fire_s  = pop_valid & pop_ready;

  assign ram_we_a      = push_fire_s;
  assign ram_addr_a    = wr_ptr_r;
  assign ram_data_in_a = push_fire_s ? push_data : {DATA_W{1'b0}};
  assign ram_addr_b    = rd_ptr_r;
  assign ram_we_b      = 1'b0;

  // Issue a RAM read when a word is stored and the skid buffer will still
  // have room for it once the in-flight word (if any) lands.
  always_comb begin
    rd_issue_s = 1'b0;
    if ((ram_cnt_r != {(ADDR_W+1){1'b0}}) &&
        (({1'b0, skid_cnt_r} + {2'b00, rd_inflight_r}) < (3'd2 + {2'b00, pop_fire_s}))) begin
      rd_issue_s = 1'b1;
    end else begin
      rd_issue_s = 1'b0;
    end
  end

  // Skid buffer next state: shift on pop first, then land the returning word
  // in the first free slot.
  always_comb begin
    skid0_nxt_s      = skid_r[0];
    skid1_nxt_s      = skid_r[1];
    skid_after_pop_s = skid_cnt_r;
    skid_cnt_nxt_s   = skid_cnt_r;
    if (pop_fire_s) begin
      skid0_nxt_s      = skid_r[1];
      skid_after_pop_s = skid_cnt_r - 2'd1;
    end else begin
      skid_after_pop_s = skid_cnt_r;
    end
    if (rd_inflight_r) begin
      if (skid_after_pop_s == 2'd0) begin
        skid0_nxt_s = ram_data_out_b;
      end else begin
        skid1_nxt_s = ram_data_out_b;
      end
      skid_cnt_nxt_s = skid_after_pop_s + 2'd1;
    end else begin
      skid_cnt_nxt_s = skid_after_pop_s;
    end
  end

  // Occupancy bookkeeping; level tracks the post-edge total exactly.
  always_comb begin
    ram_cnt_nxt_s = ram_cnt_r + (ADDR_W+1)'(push_fire_s) - (ADDR_W+1)'(rd_issue_s);
    level_nxt_s   = (ADDR_W+2)'(ram_cnt_nxt_s) + (ADDR_W+2)'(rd_issue_s)
                  + (ADDR_W+2)'(skid_cnt_nxt_s);
  end

  // Pointer, counter and skid registers; reset discards all held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r      <= {ADDR_W{1'b0}};
      rd_ptr_r      <= {ADDR_W{1'b0}};
      ram_cnt_r     <= {(ADDR_W+1){1'b0}};
      rd_inflight_r <= 1'b0;
      skid_r[0]     <= {DATA_W{1'b0}};
      skid_r[1]     <= {DATA_W{1'b0}};
      skid_cnt_r    <= 2'd0;
      level_r       <= {(ADDR_W+2){1'b0}};
    end else begin
      if (push_fire_s) begin
        wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (rd_issue_s) begin
        rd_ptr_r <= rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      ram_cnt_r     <= ram_cnt_nxt_s;
      rd_inflight_r <= rd_issue_s;
      skid_r[0]     <= skid0_nxt_s;
      skid_r[1]     <= skid1_nxt_s;
      skid_cnt_r    <= skid_cnt_nxt_s;
      level_r       <= level_nxt_s;
    end
  end

`ifdef DPF_OVF_FLAG_EN
  logic ovf_err_r;
  assign ovf_err = ovf_err_r;

  // Sticky overflow flag: a rejected push sets it, err_clr clears it, set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err_r <= 1'b0;
    end else if (push_valid && !push_ready) begin
      ovf_err_r <= 1'b1;
    end else if (err_clr) begin
      ovf_err_r <= 1'b0;
    end else begin
      ovf_err_r <= ovf_err_r;
    end
  end
`endif

endmodule
